// File: rtl/line_pingpong_pkg.sv
// Shared types and constants for the ping-pong line buffer controller.
package line_pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 9;

  // Each bank is half of the RAM: the address MSB is the bank select.
  function automatic int bank_depth(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

endpackage

// File: rtl/line_pingpong_ctrl_if.sv
// Pixel-stream and line-RAM signal bundle for line_pingpong_ctrl.
interface line_pingpong_ctrl_if #(
  parameter int ADDR_W = line_pingpong_pkg::ADDR_W_DEF,
  parameter int DATA_W = line_pingpong_pkg::DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_eol;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_eol;
  logic              out_ready;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              ram_rd_clk_en;
  logic [DATA_W-1:0] ram_rd_data;

  // The environment side: pixel source, pixel sink and the RAM itself.
  modport master (
    output in_valid, in_data, in_eol, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, out_eol,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en
  );

  modport slave (
    input  in_valid, in_data, in_eol, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, out_eol,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en
  );

endinterface

// File: rtl/line_pingpong_rd_seq.sv
// Read sequencer: issues RAM reads of the current read bank and registers
// out_valid/out_eol so they line up with the 1-cycle RAM read latency.
module line_pingpong_rd_seq
  import line_pingpong_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bank_ready,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              out_ready,
  output logic              rb,
  output logic              issue,
  output logic              rd_release,
  output logic              out_valid,
  output logic              out_eol,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rd_clk_en
);

  localparam int CNT_W = ADDR_W - 1;

  logic [CNT_W-1:0]  rcnt;
  logic [ADDR_W-1:0] addr_q;
  logic              adv;
  logic              last;

  // The RAM output only advances when the output register may take new data,
  // so a stalled pixel is held by the read clock enable.
  assign adv           = ~out_valid | out_ready;
  assign issue         = adv & bank_ready;
  assign last          = ({1'b0, rcnt} == (rd_len - ADDR_W'(1)));
  assign rd_release    = issue & last;
  assign ram_rd_clk_en = adv & ~rst;
  assign ram_rd_addr   = issue ? {rb, rcnt} : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      rb        <= 1'b0;
      addr_q    <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= issue;
        out_eol   <= issue & last;
      end
      if (issue) begin
        addr_q <= {rb, rcnt};
        if (last) begin
          rcnt <= '0;
          rb   <= ~rb;
        end else begin
          rcnt <= rcnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/line_pingpong_ctrl.sv
// Ping-pong line buffer controller over one 2-bank simple-dual-port RAM.
// Optional LINE_PINGPONG_STATS_EN adds line_cnt/drop_cnt statistics outputs.
module line_pingpong_ctrl
  import line_pingpong_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  line_pingpong_ctrl_if.slave bus,
  output logic ovf_err
`ifdef LINE_PINGPONG_STATS_EN
  ,
  output logic [15:0] line_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int BANK_D = bank_depth(ADDR_W);
  localparam int CNT_W  = ADDR_W - 1;

  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic              wb;
  logic [CNT_W-1:0]  wcnt;
  logic [ADDR_W-1:0] len_q [2];
  logic              discard;

  logic wr_blocked;
  logic accept;
  logic wr;
  logic wcnt_full;
  logic close;
  logic ovf;

  logic              rb;
  logic              issue;
  logic              rd_release;
  logic              bank_ready;
  logic [ADDR_W-1:0] rd_len;

  assign wr_blocked = (bank_q[wb] == FULL) || (bank_q[wb] == DRAINING);
  assign bus.in_ready = ~rst & (~wr_blocked | discard);
  assign accept     = bus.in_valid & bus.in_ready;
  assign wr         = accept & ~discard;
  assign wcnt_full  = (wcnt == CNT_W'(BANK_D - 1));
  assign close      = wr & (bus.in_eol | wcnt_full);
  assign ovf        = wr & wcnt_full & ~bus.in_eol;

  assign bus.ram_wr_en   = wr;
  assign bus.ram_wr_addr = {wb, wcnt};
  assign bus.ram_wr_data = DATA_W'(bus.in_data);
  assign bus.out_data    = DATA_W'(bus.ram_rd_data);
  assign ovf_err         = ovf;

  assign bank_ready = (bank_q[rb] == FULL) || (bank_q[rb] == DRAINING);
  assign rd_len     = len_q[rb];

  line_pingpong_rd_seq #(
    .ADDR_W(ADDR_W)
  ) u_rd_seq (
    .clk          (clk),
    .rst          (rst),
    .bank_ready   (bank_ready),
    .rd_len       (rd_len),
    .out_ready    (bus.out_ready),
    .rb           (rb),
    .issue        (issue),
    .rd_release   (rd_release),
    .out_valid    (bus.out_valid),
    .out_eol      (bus.out_eol),
    .ram_rd_addr  (bus.ram_rd_addr),
    .ram_rd_clk_en(bus.ram_rd_clk_en)
  );

  // Writer and reader never touch the same bank in one cycle: the writer
  // only acts on EMPTY/FILLING banks, the reader only on FULL/DRAINING ones.
  always_comb begin
    bank_d = bank_q;
    if (wr) begin
      bank_d[wb] = close ? FULL : FILLING;
    end
    if (issue) begin
      bank_d[rb] = rd_release ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wb        <= 1'b0;
      wcnt      <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      discard   <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (close) begin
        len_q[wb] <= {1'b0, wcnt} + ADDR_W'(1);
        wb        <= ~wb;
        wcnt      <= '0;
      end else if (wr) begin
        wcnt <= wcnt + CNT_W'(1);
      end
      // The tail of an overlong line is swallowed up to and including its eol.
      if (ovf) begin
        discard <= 1'b1;
      end else if (accept & discard & bus.in_eol) begin
        discard <= 1'b0;
      end
    end
  end

`ifdef LINE_PINGPONG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (close) begin
        line_cnt <= line_cnt + 16'd1;
      end
      if (accept & discard & (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_pingpong_ctrl.sv
// Self-checking bench for line_pingpong_ctrl with a line-level reference model.
// Build with LINE_PINGPONG_STATS_EN to also check the statistics outputs.
module tb_line_pingpong_ctrl;

  localparam int BANK_D = 1024;

  logic clk;
  logic rst;
  logic ovf_err;
`ifdef LINE_PINGPONG_STATS_EN
  logic [15:0] line_cnt;
  logic [15:0] drop_cnt;
`endif

  line_pingpong_ctrl_if bus ();

  line_pingpong_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
`ifdef LINE_PINGPONG_STATS_EN
    .line_cnt(line_cnt),
    .drop_cnt(drop_cnt),
`endif
    .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2048x9 RAM, read port registered under its clock enable.
  logic [8:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.ram_wr_en) ram[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_clk_en) bus.ram_rd_data <= ram[bus.ram_rd_addr];
  end

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int out_count = 0;
  int ovf_seen = 0;
  int ready_mode = 1;
  bit gaps = 1'b0;

  logic [9:0] src_q [$];
  logic [9:0] exp_q [$];
  int m_pos;
  bit m_bank;
  int m_lines;
  int m_drops;
  bit prev_stall;
  logic [8:0] prev_data;
  logic prev_eol;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    src_q.delete();
    exp_q.delete();
    m_pos = 0;
    m_bank = 1'b0;
    m_lines = 0;
    m_drops = 0;
    prev_stall = 1'b0;
  endtask

  // Line-level rules: the first BANK_D pixels of each input line are stored in
  // alternating banks and replayed; the 1024th pixel closes an overlong line.
  task automatic model_accept(input logic [8:0] d, input logic e);
    bit closes;
    if (m_pos < BANK_D) begin
      closes = e || (m_pos == BANK_D - 1);
      check_output("wr_en", bus.ram_wr_en, 1);
      check_output("wr_addr", bus.ram_wr_addr, m_bank ? BANK_D + m_pos : m_pos);
      check_output("wr_data", bus.ram_wr_data, d);
      check_output("ovf_err", ovf_err, (m_pos == BANK_D - 1) && !e);
      exp_q.push_back({closes, d});
      if (closes) begin
        m_lines++;
        m_bank = !m_bank;
      end
    end else begin
      check_output("drop_wr_en", bus.ram_wr_en, 0);
      check_output("drop_ovf", ovf_err, 0);
      m_drops++;
    end
    m_pos = e ? 0 : m_pos + 1;
  endtask

  // One clock: drive at the falling edge, sample just after it.
  task automatic apply_stimulus();
    logic [9:0] e;
    @(negedge clk);
    if (src_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      bus.in_valid = 1'b1;
      bus.in_data  = src_q[0][8:0];
      bus.in_eol   = src_q[0][9];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_eol   = 1'b0;
    end
    case (ready_mode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(1));
    endcase
    #1;
    if (ovf_err) ovf_seen++;
    if (bus.in_valid && bus.in_ready) begin
      model_accept(bus.in_data, bus.in_eol);
      void'(src_q.pop_front());
    end else begin
      check_output("wr_idle", bus.ram_wr_en, 0);
    end
    if (prev_stall) begin
      check_output("hold_valid", bus.out_valid, 1);
      check_output("hold_data", bus.out_data, prev_data);
      check_output("hold_eol", bus.out_eol, prev_eol);
    end
    if (bus.out_valid && bus.out_ready) begin
      check_output("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("out_data", bus.out_data, e[8:0]);
        check_output("out_eol", bus.out_eol, e[9]);
        out_count++;
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_eol   = bus.out_eol;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_eol = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_eol", bus.out_eol, 0);
    check_output("rst_wr_en", bus.ram_wr_en, 0);
    check_output("rst_rd_clk_en", bus.ram_rd_clk_en, 0);
    check_output("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    #1;
    check_output("rst_in_ready", bus.in_ready, 1);
  endtask

  task automatic push_line(input int n, input int start);
    logic [8:0] d;
    logic e;
    for (int i = 0; i < n; i++) begin
      d = 9'(start + i);
      e = (i == n - 1);
      src_q.push_back({e, d});
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < max_cycles) begin
      apply_stimulus();
      k++;
    end
    check_output("drain_done", src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int k;
    bit found;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_eol = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset, then a 4-pixel line with the sink always ready.
    apply_reset();
    ready_mode = 1;
    push_line(4, 1);
    k = 0;
    while (src_q.size() != 0 && k < 20) begin
      apply_stimulus();
      k++;
    end
    apply_stimulus();
    check_output("first_issue_en", bus.ram_rd_clk_en, 1);
    check_output("first_issue_addr", bus.ram_rd_addr, 0);
    check_output("first_issue_valid", bus.out_valid, 0);
    apply_stimulus();
    check_output("first_valid", bus.out_valid, 1);
    check_output("first_data", bus.out_data, 1);
    drain(40);

    // Two 8-pixel lines fill both banks while the sink is stalled.
    apply_reset();
    ready_mode = 0;
    push_line(8, 16);
    push_line(8, 32);
    push_line(8, 48);
    k = 0;
    while (src_q.size() > 8 && k < 40) begin
      apply_stimulus();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output("in_ready_full", bus.in_ready, 0);
      check_output("stall_rd_clk_en", bus.ram_rd_clk_en, 0);
    end
    ready_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      apply_stimulus();
      if (bus.ram_rd_clk_en && bus.ram_rd_addr == 11'd7) found = 1'b1;
    end
    check_output("last_issue_seen", found, 1);
    check_output("in_ready_before_release", bus.in_ready, 0);
    apply_stimulus();
    check_output("in_ready_after_release", bus.in_ready, 1);
    drain(100);

    // Overlong 1030-pixel line.
    ovf_seen = 0;
    base = out_count;
    push_line(1030, 0);
    drain(3000);
    check_output("ovf_pulses", ovf_seen, 1);
    check_output("ovf_out_count", out_count - base, BANK_D);

    // Random sink back-pressure and source gaps on a 0..15 ramp.
    ready_mode = 2;
    gaps = 1'b1;
    base = out_count;
    push_line(16, 0);
    drain(400);
    check_output("ramp_out_count", out_count - base, 16);
    gaps = 1'b0;

    // Reset in the middle of draining a line.
    apply_reset();
    ready_mode = 0;
    push_line(8, 64);
    k = 0;
    while (src_q.size() != 0 && k < 20) begin
      apply_stimulus();
      k++;
    end
    ready_mode = 1;
    base = out_count;
    k = 0;
    while (out_count - base < 3 && k < 30) begin
      apply_stimulus();
      k++;
    end
    bus.out_ready = 1'b0;
    check_output("mid_drain_outputs", out_count - base, 3);
    apply_reset();
    ready_mode = 1;
    base = out_count;
    push_line(2, 9'h1A5);
    drain(40);
    for (int i = 0; i < 5; i++) apply_stimulus();
    check_output("post_rst_out_count", out_count - base, 2);

`ifdef LINE_PINGPONG_STATS_EN
    apply_reset();
    ready_mode = 1;
    push_line(5, 100);
    push_line(1026, 200);
    push_line(3, 300);
    drain(3000);
    check_output("line_cnt", line_cnt, m_lines);
    check_output("drop_cnt", drop_cnt, m_drops);
    check_output("line_cnt_abs", line_cnt, 3);
    check_output("drop_cnt_abs", drop_cnt, 2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_pingpong_ctrl.md
Name: line_pingpong_ctrl

Overview:
- Sequences one 2048x9 simple-dual-port line RAM (11-bit address, 9-bit data, 1-cycle read latency, read clock enable, no output register) as a ping-pong line buffer.
- Address MSB selects the bank: bank 0 is 0..1023, bank 1 is 1024..2047.
- Captures one video line into the write bank while streaming the previous line out of the other bank over a valid/ready interface.
- Sits between the capture pixel stream and downstream processing.
- The RAM's write and read clocks are both tied to clk.

Parameters:
- ADDR_W, 11, RAM address width; bank depth BANK_D = 2^(ADDR_W-1) = 1024.
- DATA_W, 9, pixel/RAM data width.

Ports:
- clk  in  1  single clock for the block and both RAM ports.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  input pixel.
- in_eol  in  1  last pixel of the line; qualified by in_valid.
- in_ready  out  1  input accepted when in_valid&in_ready.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_W  output pixel; driven directly from ram_rd_data.
- out_eol  out  1  last pixel of the drained line.
- out_ready  in  1  downstream accept.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_clk_en  out  1  RAM read clock enable (read issue/hold).
- ram_rd_data  in  DATA_W  RAM read data.
- ovf_err  out  1  one-cycle pulse: line exceeded BANK_D.

Behaviour:
- Reset (sync, rst=1 at clk edge) gives:
  - bank states EMPTY/EMPTY; wb=0, rb=0; wcnt=0, rcnt=0; len0=len1=0; discard=0.
  - out_valid=0, out_eol=0, ovf_err=0, in_ready=1 (after the reset cycle).
  - ram_wr_en=0, ram_rd_clk_en=0.
  - Reset mid-line or mid-drain abandons all data; no partial output is emitted after reset.
- Bank state per bank: EMPTY -> FILLING (first accepted pixel) -> FULL (line closed) -> DRAINING (read starts) -> EMPTY (last read issued).
- Write side (combinational outputs):
  - in_ready = (bank[wb] != FULL && bank[wb] != DRAINING) || discard.
  - ram_wr_en = in_valid & in_ready & ~discard; ram_wr_addr = {wb, wcnt}; ram_wr_data = in_data.
  - On an accepted, written pixel: wcnt++.
  - Line close, when in_eol or wcnt == BANK_D-1:
    - len[wb] = wcnt+1; bank[wb] = FULL; wb toggles; wcnt = 0.
  - Overflow: close occurs at wcnt == BANK_D-1 without in_eol.
    - ovf_err pulses 1 cycle; discard=1.
    - Later pixels are accepted (in_ready=1) but not written, through and including the next in_eol; that eol clears discard.
- Read side:
  - Issue condition: adv = ~out_valid | out_ready.
  - ram_rd_clk_en = adv.
  - ram_rd_addr = {rb, rcnt} when reading, otherwise held.
  - When bank[rb] is FULL or DRAINING and adv: read issues.
    - Next cycle: out_valid=1, out_eol = (issued rcnt == len[rb]-1).
    - rcnt++; bank DRAINING.
  - When adv and nothing to issue: out_valid=0.
  - When ~adv: RAM output is held by clock enable; out_valid/out_data/out_eol are stable.
- Release timing:
  - The last read issued sets bank[rb]=EMPTY, rb toggles, rcnt=0, in the same cycle.
  - The writer may target that bank on the next cycle; the latched RAM output is unaffected.
- Throughput and latency:
  - 1 pixel/cycle on each side.
  - Latency from FULL to first out_valid: 1 cycle (issue, then data).
- Simultaneous events:
  - Write close on one bank and read release on the other in the same cycle are both applied.
  - If in_ready was low, the writer resumes the cycle after release.
- Both banks FULL: in_ready=0 until a release.

Optional Feature:
- Macro: LINE_PINGPONG_STATS_EN.
- Defined: adds outputs line_cnt[15:0] (lines closed, wraps at 65535->0) and drop_cnt[15:0] (pixels discarded in overflow, saturates at 65535); both cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package line_pingpong_pkg:
  - bank_state_t enum {EMPTY, FILLING, FULL, DRAINING}.
  - Constants ADDR_W_DEF=11, DATA_W_DEF=9.
  - Function bank_depth(addr_w).
- One sub-module: line_pingpong_rd_seq (read issue, rcnt, out_valid/out_eol register, clock-enable generation). The write side stays inline.

Test Plan:
- Reset then a 4-pixel line 1,2,3,4 with eol on 4, out_ready=1:
  - writes to addr 0..3.
  - out_data 1,2,3,4 from cycle 1 after close; out_eol only on 4.
  - bank0 EMPTY after the issue of addr 3.
- Back-to-back 8-pixel lines, out_ready=0:
  - lines 1 and 2 fill banks 0/1 (addrs 0..7, 1024..1031); then in_ready=0.
  - Raise out_ready: line 1 drains; in_ready returns 1 the cycle after release.
- 1030-pixel line:
  - addrs 0..1023 written; ovf_err pulses once at pixel 1024; pixels 1025..1030 accepted, not written.
  - Output is 1024 pixels with out_eol on the 1024th.
- Random out_ready toggling on a 16-pixel ramp 0..15:
  - output sequence exactly 0..15, no duplicates or drops.
  - out_data stable while out_valid & ~out_ready.
- rst asserted mid-drain (after 3 of 8 outputs):
  - next cycle out_valid=0, in_ready=1.
  - A new 2-pixel line outputs only its own 2 pixels from bank 0.
- With LINE_PINGPONG_STATS_EN: after three lines, one of them 1026 pixels, line_cnt=3 and drop_cnt=2.
